// File: rtl/fibo_pkg.sv
// Shared definitions for the Fibonacci sequence engine: FSM state encoding
// and the pointer-width helper used to size register-file addresses.
package fibo_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD0 = 3'd1,
    ST_LOAD1 = 3'd2,
    ST_EMIT  = 3'd3,
    ST_ADD   = 3'd4,
    ST_DONE  = 3'd5
  } fibo_state_e;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((32'sd1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/fibo_regfile.sv
// NREGS x WIDTH term history: one write port, combinational read ports for
// the two adder operands, the emitted term and the history tap.
module fibo_regfile
  import fibo_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int NREGS = 4,
  parameter int PW    = clog2(NREGS)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             we,
  input  logic [PW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [PW-1:0]    ra_addr,
  output logic [WIDTH-1:0] ra_data,
  input  logic [PW-1:0]    rb_addr,
  output logic [WIDTH-1:0] rb_data,
  input  logic [PW-1:0]    re_addr,
  output logic [WIDTH-1:0] re_data,
  input  logic [PW-1:0]    rh_addr,
  output logic [WIDTH-1:0] rh_data
);

  logic [WIDTH-1:0] mem_r [NREGS];

  // storage array with single write port
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) mem_r[i] <= {WIDTH{1'b0}};
    end else if (we) begin
      mem_r[waddr] <= wdata;
    end
  end

  assign ra_data = mem_r[ra_addr];
  assign rb_data = mem_r[rb_addr];
  assign re_data = mem_r[re_addr];
  assign rh_data = mem_r[rh_addr];

endmodule

// File: rtl/fibo_seq_engine.sv
// Fibonacci sequence engine: controller FSM, term counter, adder and flags
// around fibo_regfile. Define FIBO_SAT_EN to saturate sums on carry.
module fibo_seq_engine
  import fibo_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int NREGS = 4,
  parameter int CNTW  = 8,
  parameter int PW    = clog2(NREGS)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] seed0,
  input  logic [WIDTH-1:0] seed1,
  input  logic [CNTW-1:0]  num_terms,
  output logic [WIDTH-1:0] term_data,
  output logic             term_valid,
  input  logic             term_ready,
  output logic             zero_flag,
  output logic             overflow,
  output logic             busy,
  output logic             done,
  input  logic [PW-1:0]    hist_sel,
  output logic [WIDTH-1:0] hist_data
);

  localparam logic [PW-1:0]   PTR_ZERO = {PW{1'b0}};
  localparam logic [PW-1:0]   PTR_ONE  = {{(PW-1){1'b0}}, 1'b1};
  localparam logic [PW-1:0]   PTR_TWO  = {{(PW-2){1'b0}}, 2'b10};
  localparam logic [CNTW-1:0] CNT_ZERO = {CNTW{1'b0}};
  localparam logic [CNTW-1:0] CNT_ONE  = {{(CNTW-1){1'b0}}, 1'b1};

  fibo_state_e      state_r, state_s;
  logic [PW-1:0]    wp_r, ep_r;
  logic [CNTW-1:0]  cnt_r;
  logic [WIDTH-1:0] seed0_r, seed1_r;
  logic             ovf_r;

  logic             we_s;
  logic [PW-1:0]    waddr_s;
  logic [WIDTH-1:0] wdata_s;
  logic [WIDTH-1:0] ra_data_s, rb_data_s, re_data_s;
  logic [WIDTH:0]   sum_s;
  logic             carry_s;
  logic [WIDTH-1:0] add_term_s;
  logic             hs_s;
  logic [CNTW-1:0]  cnt_dec_s;
  logic [PW-1:0]    ep_inc_s;

  fibo_regfile #(.WIDTH(WIDTH), .NREGS(NREGS), .PW(PW)) u_regfile (
    .clk     (clk),
    .rst_n   (rst_n),
    .we      (we_s),
    .waddr   (waddr_s),
    .wdata   (wdata_s),
    .ra_addr (wp_r - PTR_ONE),
    .ra_data (ra_data_s),
    .rb_addr (wp_r - PTR_TWO),
    .rb_data (rb_data_s),
    .re_addr (ep_r),
    .re_data (re_data_s),
    .rh_addr (wp_r - PTR_ONE - hist_sel),
    .rh_data (hist_data)
  );

  assign sum_s     = {1'b0, ra_data_s} + {1'b0, rb_data_s};
  assign carry_s   = sum_s[WIDTH];
  assign hs_s      = (state_r == ST_EMIT) && term_ready;
  assign cnt_dec_s = cnt_r - CNT_ONE;
  assign ep_inc_s  = ep_r + PTR_ONE;

`ifdef FIBO_SAT_EN
  assign add_term_s = carry_s ? {WIDTH{1'b1}} : sum_s[WIDTH-1:0];
`else
  assign add_term_s = sum_s[WIDTH-1:0];
`endif

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_r <= ST_IDLE;
    else        state_r <= state_s;
  end

  // next-state logic
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE:  if (start) state_s = ST_LOAD0; else state_s = ST_IDLE;
      ST_LOAD0: state_s = ST_LOAD1;
      ST_LOAD1: if (cnt_r == CNT_ZERO) state_s = ST_DONE; else state_s = ST_EMIT;
      ST_EMIT: begin
        if (hs_s) begin
          if (cnt_dec_s == CNT_ZERO)  state_s = ST_DONE;
          else if (ep_inc_s == wp_r) state_s = ST_ADD;
          else                       state_s = ST_EMIT;
        end else begin
          state_s = ST_EMIT;
        end
      end
      ST_ADD:   state_s = ST_EMIT;
      ST_DONE:  state_s = ST_IDLE;
      default:  state_s = ST_IDLE;
    endcase
  end

  // register-file write port: seeds in LOAD0/LOAD1, sums in ADD
  always_comb begin
    we_s    = 1'b0;
    waddr_s = PTR_ZERO;
    wdata_s = {WIDTH{1'b0}};
    case (state_r)
      ST_LOAD0: begin we_s = 1'b1; waddr_s = PTR_ZERO; wdata_s = seed0_r;    end
      ST_LOAD1: begin we_s = 1'b1; waddr_s = PTR_ONE;  wdata_s = seed1_r;    end
      ST_ADD:   begin we_s = 1'b1; waddr_s = wp_r;     wdata_s = add_term_s; end
      default:  begin we_s = 1'b0; waddr_s = PTR_ZERO; wdata_s = {WIDTH{1'b0}}; end
    endcase
  end

  // datapath registers: seeds, count, pointers and sticky overflow
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seed0_r <= {WIDTH{1'b0}};
      seed1_r <= {WIDTH{1'b0}};
      cnt_r   <= CNT_ZERO;
      wp_r    <= PTR_ZERO;
      ep_r    <= PTR_ZERO;
      ovf_r   <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (start) begin
            seed0_r <= seed0;
            seed1_r <= seed1;
            cnt_r   <= num_terms;
            wp_r    <= PTR_ZERO;
            ep_r    <= PTR_ZERO;
            ovf_r   <= 1'b0;
          end
        end
        ST_LOAD0: wp_r <= PTR_ONE;
        ST_LOAD1: wp_r <= PTR_TWO;
        ST_EMIT: begin
          if (hs_s) begin
            cnt_r <= cnt_dec_s;
            ep_r  <= ep_inc_s;
          end
        end
        ST_ADD: begin
          wp_r <= wp_r + PTR_ONE;
          if (carry_s) ovf_r <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  // outputs decoded from the registered state; term_data is held at zero outside EMIT
  always_comb begin
    term_valid = 1'b0;
    term_data  = {WIDTH{1'b0}};
    busy       = (state_r != ST_IDLE);
    done       = (state_r == ST_DONE);
    overflow   = ovf_r;
    if (state_r == ST_EMIT) begin
      term_valid = 1'b1;
      term_data  = re_data_s;
    end else begin
      term_valid = 1'b0;
      term_data  = {WIDTH{1'b0}};
    end
    zero_flag = term_valid && (term_data == {WIDTH{1'b0}});
  end

endmodule

// File: tb/tb_fibo_seq_engine.sv
// Scoreboard bench for fibo_seq_engine: a reference model pushes expected
// terms when a run starts; a negedge monitor pops them on every handshake.
module tb_fibo_seq_engine;

  localparam int WIDTH = 8;
  localparam int NREGS = 4;
  localparam int CNTW  = 8;
  localparam int PW    = 2;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             start;
  logic [WIDTH-1:0] seed0, seed1;
  logic [CNTW-1:0]  num_terms;
  logic [WIDTH-1:0] term_data;
  logic             term_valid;
  logic             term_ready;
  logic             zero_flag, overflow, busy, done;
  logic [PW-1:0]    hist_sel;
  logic [WIDTH-1:0] hist_data;

  int checks = 0;
  int errors = 0;
  int hs_cnt = 0;
  int done_cnt = 0;
  logic             stall_prev = 1'b0;
  logic [WIDTH-1:0] stall_data = '0;
  logic [WIDTH-1:0] exp_q[$];
  logic [WIDTH-1:0] model_terms[$];
  logic             exp_ovf = 1'b0;

  fibo_seq_engine #(.WIDTH(WIDTH), .NREGS(NREGS), .CNTW(CNTW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .seed0      (seed0),
    .seed1      (seed1),
    .num_terms  (num_terms),
    .term_data  (term_data),
    .term_valid (term_valid),
    .term_ready (term_ready),
    .zero_flag  (zero_flag),
    .overflow   (overflow),
    .busy       (busy),
    .done       (done),
    .hist_sel   (hist_sel),
    .hist_data  (hist_data)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // reference model: all generated terms go to model_terms, the first n to the scoreboard
  task automatic push_model(input logic [WIDTH-1:0] s0, input logic [WIDTH-1:0] s1, input int n);
    logic [WIDTH-1:0] p2, p1, t;
    logic [WIDTH:0]   s;
    model_terms.delete();
    exp_ovf = 1'b0;
    p2 = s0;
    p1 = s1;
    model_terms.push_back(s0);
    model_terms.push_back(s1);
    if (n >= 1) exp_q.push_back(s0);
    if (n >= 2) exp_q.push_back(s1);
    for (int k = 2; k < n; k++) begin
      s = {1'b0, p1} + {1'b0, p2};
      t = s[WIDTH-1:0];
      if (s[WIDTH]) begin
        exp_ovf = 1'b1;
`ifdef FIBO_SAT_EN
        t = {WIDTH{1'b1}};
`endif
      end
      exp_q.push_back(t);
      model_terms.push_back(t);
      p2 = p1;
      p1 = t;
    end
  endtask

  task automatic start_run(input logic [WIDTH-1:0] s0, input logic [WIDTH-1:0] s1, input int n);
    @(posedge clk); #1;
    seed0 = s0;
    seed1 = s1;
    num_terms = CNTW'(n);
    start = 1'b1;
    push_model(s0, s1, n);
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int base;
    base = done_cnt;
    for (int c = 0; c < budget; c++) begin
      @(negedge clk); #2;
      if (done_cnt != base) break;
    end
    check_eq({tag, "_done_seen"}, 32'(done_cnt != base), 32'd1);
    check_eq({tag, "_drained"}, exp_q.size(), 32'd0);
    @(negedge clk); #2;
    check_eq({tag, "_done_pulse"}, done, 1'b0);
    check_eq({tag, "_idle"}, busy, 1'b0);
  endtask

  // monitor: handshakes, stall stability and done pulses
  initial begin
    logic [WIDTH-1:0] e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        stall_prev = 1'b0;
      end else begin
        if (done) done_cnt++;
        if (term_valid && !term_ready) begin
          if (stall_prev) check_eq("stall_hold", term_data, stall_data);
          stall_prev = 1'b1;
          stall_data = term_data;
        end else if (term_valid) begin
          if (stall_prev) check_eq("stall_release", term_data, stall_data);
          stall_prev = 1'b0;
          hs_cnt++;
          if (exp_q.size() == 0) begin
            check_eq("unexpected_term", exp_q.size(), 32'd1);
          end else begin
            e = exp_q.pop_front();
            check_eq("term", term_data, e);
            check_eq("zero_flag", zero_flag, 32'(e == '0));
          end
        end else begin
          stall_prev = 1'b0;
        end
      end
    end
  end

  initial begin
    int base_hs;
    int found;
    int dbase;
    rst_n = 1'b0;
    start = 1'b0;
    term_ready = 1'b1;
    seed0 = '0;
    seed1 = '0;
    num_terms = '0;
    hist_sel = '0;
    #1;
    check_eq("rst_valid", term_valid, 1'b0);
    check_eq("rst_data", term_data, 8'd0);
    check_eq("rst_busy", busy, 1'b0);
    check_eq("rst_done", done, 1'b0);
    check_eq("rst_ovf", overflow, 1'b0);
    check_eq("rst_zero", zero_flag, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // 1: 0/1, N=8, first-term latency
    start_run(8'd0, 8'd1, 8);
    @(negedge clk); check_eq("lat_load0", term_valid, 1'b0);
    @(negedge clk); check_eq("lat_load1", term_valid, 1'b0);
    @(negedge clk); check_eq("lat_first", term_valid, 1'b1);
    wait_done("t1", 200);
    check_eq("t1_ovf", overflow, exp_ovf);

    // 2: overflow on the fourth term
    start_run(8'd89, 8'd144, 4);
    wait_done("t2", 200);
    check_eq("t2_ovf", overflow, exp_ovf);

    // 3: consumer stalls every 3 cycles
    start_run(8'd3, 8'd5, 5);
    dbase = done_cnt;
    for (int c = 0; c < 500; c++) begin
      @(posedge clk); #1;
      if (c % 3 == 2) term_ready = ~term_ready;
      if (done_cnt != dbase) break;
    end
    term_ready = 1'b1;
    check_eq("t3_done_seen", 32'(done_cnt != dbase), 32'd1);
    check_eq("t3_drained", exp_q.size(), 32'd0);

    // 4: N=0 done timing, then N=1
    base_hs = hs_cnt;
    start_run(8'd0, 8'd0, 0);
    @(negedge clk); check_eq("n0_early_done", done, 1'b0);
    @(negedge clk);
    @(negedge clk); check_eq("n0_done_latency", done, 1'b1);
    @(negedge clk); check_eq("n0_idle", busy, 1'b0);
    check_eq("n0_no_terms", hs_cnt - base_hs, 32'd0);
    start_run(8'd0, 8'd7, 1);
    wait_done("n1", 200);

    // 5: reset during term 4, replay, start while busy
    hs_cnt = 0;
    start_run(8'd0, 8'd1, 8);
    found = 0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk); #2;
      if (hs_cnt == 4 && term_valid) begin found = 1; break; end
    end
    check_eq("t5_reach_term4", found, 1);
    rst_n = 1'b0;
    #1;
    check_eq("t5_rst_valid", term_valid, 1'b0);
    check_eq("t5_rst_data", term_data, 8'd0);
    check_eq("t5_rst_busy", busy, 1'b0);
    check_eq("t5_rst_hist", hist_data, 8'd0);
    exp_q.delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    start_run(8'd0, 8'd1, 8);
    repeat (4) @(posedge clk);
    #1;
    seed0 = 8'd50; seed1 = 8'd60; num_terms = 8'd3;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done("t5", 200);

    // 6: history after wrap
    start_run(8'd1, 8'd1, 10);
    wait_done("t6", 300);
    for (int i = 0; i < 4; i++) begin
      hist_sel = PW'(i);
      #1;
      check_eq($sformatf("hist%0d", i), hist_data, model_terms[model_terms.size() - 1 - i]);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
